// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the divide sequencer.
// State encoding is fixed so it can be probed from outside.
package div_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DRAIN = 2'b11
    } state_e;

    localparam int DIV_TIMEOUT = 64;
    localparam int DIV_CNT_W   = 7;

endpackage

// File: rtl/div_sched_hilo.sv
// HI/LO architectural registers with an mthi/mtlo port
// and a divide commit port; commit wins if both fire.
module hilo_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        mt_hi_we,
    input  logic        mt_lo_we,
    input  logic [31:0] mt_wdata,
    input  logic        cm_we,
    input  logic [31:0] cm_hi,
    input  logic [31:0] cm_lo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (cm_we) begin
            hi_d = cm_hi;
            lo_d = cm_lo;
        end else begin
            if (mt_hi_we) hi_d = mt_wdata;
            if (mt_lo_we) lo_d = mt_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/div_sched.sv
// Sequencer between EX and the iterative divider: issue,
// wait with watchdog, drain on flush, commit to HI/LO.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int TIMEOUT = DIV_TIMEOUT,
    parameter int CNT_W   = DIV_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,
    input  logic        mt_hi_we,
    input  logic        mt_lo_we,
    input  logic [31:0] mt_wdata,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        err_timeout,
    output logic        div_en,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_busy,
    input  logic        div_complete,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic [31:0]      dvd_q, dvd_d;
    logic [31:0]      dvs_q, dvs_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             idle, accept, div0, tmo, cm_we;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cm_we   = 1'b0;

        idle      = (state_q == S_IDLE);
        req_ready = idle & ~mt_hi_we & ~mt_lo_we;
        accept    = req_valid & req_ready;
        div0      = (req_divisor == '0);
        stall     = ~idle | (accept & ~div0);
        // >= so a flush landing on the last count still expires in DRAIN
        tmo       = (cnt_q >= CNT_W'(TIMEOUT - 1));

        unique case (state_q)
            S_IDLE: begin
                if (accept & ~flush) begin
                    if (div0) begin
                        done_d = 1'b1;
                    end else begin
                        sgn_d   = req_signed;
                        dvd_d   = req_dividend;
                        dvs_d   = req_divisor;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(1);
                state_d = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (flush) begin
                    state_d = div_complete ? S_IDLE : S_DRAIN;
                end else if (div_complete) begin
                    cm_we   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (div_complete) begin
                    state_d = S_IDLE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    hilo_regs u_hilo (
        .clk      (clk),
        .reset    (reset),
        .mt_hi_we (mt_hi_we & idle),
        .mt_lo_we (mt_lo_we & idle),
        .mt_wdata (mt_wdata),
        .cm_we    (cm_we),
        .cm_hi    (div_remainder),
        .cm_lo    (div_quotient),
        .hi       (hi),
        .lo       (lo)
    );

    assign div_en       = (state_q == S_ISSUE);
    assign div_signed   = sgn_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign done         = done_q;
    assign err_timeout  = err_q;

    a_en_pulse: assert property (
        @(posedge clk) disable iff (reset) div_en |=> !div_en);

    // a hung divider may still be busy; only legal once flagged
    a_issue_idle: assert property (
        @(posedge clk) disable iff (reset)
        div_en |-> (!div_busy || err_q));

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural divider
// of fixed latency, a hang switch and a stale-complete drive.
module tb_div_sched;

    localparam int TO  = 64;
    localparam int LAT = 33;

    logic        clk = 0;
    logic        reset;
    logic        req_valid, req_ready, req_signed;
    logic [31:0] req_dividend, req_divisor;
    logic        mt_hi_we, mt_lo_we;
    logic [31:0] mt_wdata;
    logic        flush, stall;
    logic [31:0] hi, lo;
    logic        done, err_timeout;
    logic        div_en, div_signed;
    logic [31:0] div_dividend, div_divisor;
    logic        div_busy, div_complete;
    logic [31:0] div_quotient, div_remainder;

    logic        m_busy, hang, stale;
    int          m_cnt;
    logic [31:0] m_q, m_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_sched #(.TIMEOUT(TO), .CNT_W(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_signed    (req_signed),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .mt_hi_we      (mt_hi_we),
        .mt_lo_we      (mt_lo_we),
        .mt_wdata      (mt_wdata),
        .flush         (flush),
        .stall         (stall),
        .hi            (hi),
        .lo            (lo),
        .done          (done),
        .err_timeout   (err_timeout),
        .div_en        (div_en),
        .div_signed    (div_signed),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_busy      (div_busy),
        .div_complete  (div_complete),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    // behavioural divider: complete LAT+1 cycles after div_en
    assign div_busy      = m_busy;
    assign div_complete  = (m_busy && m_cnt == 0 && !hang) || stale;
    assign div_quotient  = stale ? 32'hDEAD_BEEF : m_q;
    assign div_remainder = stale ? 32'hBAD0_BAD0 : m_r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_q    <= '0;
            m_r    <= '0;
        end else if (div_en) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT;
            if (div_signed) begin
                m_q <= $signed(div_dividend) / $signed(div_divisor);
                m_r <= $signed(div_dividend) % $signed(div_divisor);
            end else begin
                m_q <= div_dividend / div_divisor;
                m_r <= div_dividend % div_divisor;
            end
        end else if (m_busy && m_cnt == 0 && !hang) begin
            m_busy <= 1'b0;
        end else if (m_busy && m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one request; returns div_en count, cycles to done, stall ok
    task automatic run_div(input logic s, input logic [31:0] a,
                           input logic [31:0] b, output int ens,
                           output int lat, output int dones,
                           output bit st_ok);
        ens = 0; lat = -1; dones = 0; st_ok = 1;
        @(negedge clk);
        req_valid = 1; req_signed = s;
        req_dividend = a; req_divisor = b;
        #1;
        if (!req_ready) st_ok = 0;
        if (stall !== (b != 0)) st_ok = 0;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            req_valid = 0;
            #1;
            if (div_en) ens++;
            if (done) begin
                dones++;
                if (lat < 0) lat = i;
            end
            if (lat < 0 && stall !== (b != 0)) st_ok = 0;
            if (lat >= 0 && stall) st_ok = 0;
            if (lat >= 0 && i > lat + 3) break;
        end
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          ens;
        int          lat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int ens, lat, dones, n, first;
        bit st_ok;

        tbl[0] = '{1'b1, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 36};
        tbl[1] = '{1'b0, 32'hFFFF_FFFF, 32'd16,
                   32'h0000_000F, 32'h0FFF_FFFF, 1, 36};
        tbl[2] = '{1'b0, 32'd100, 32'd0,
                   32'h0000_000F, 32'h0FFF_FFFF, 0, 1};
        tbl[3] = '{1'b0, 32'd1000, 32'd7,
                   32'd6, 32'd142, 1, 36};
        tbl[4] = '{1'b1, 32'd7, 32'hFFFF_FFFE,
                   32'd1, 32'hFFFF_FFFD, 1, 36};
        tbl[5] = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD,
                   32'hFFFF_FFFE, 32'd2, 1, 36};

        reset = 1; req_valid = 0; req_signed = 0;
        req_dividend = 0; req_divisor = 0;
        mt_hi_we = 0; mt_lo_we = 0; mt_wdata = 0;
        flush = 0; hang = 0; stale = 0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_en", div_en, 0);
        chk("rst_stall", stall, 0);
        chk("rst_state", dut.state_q, 2'b00);
        @(negedge clk);
        reset = 0;

        for (int k = 0; k < 6; k++) begin
            run_div(tbl[k].sgn, tbl[k].a, tbl[k].b,
                    ens, lat, dones, st_ok);
            chk($sformatf("v%0d_hi", k), hi, tbl[k].hi);
            chk($sformatf("v%0d_lo", k), lo, tbl[k].lo);
            chk($sformatf("v%0d_en", k), ens, tbl[k].ens);
            chk($sformatf("v%0d_lat", k), lat, tbl[k].lat);
            chk($sformatf("v%0d_dones", k), dones, 1);
            chk($sformatf("v%0d_stall", k), st_ok, 1);
        end

        // flush in IDLE drops a same-cycle request
        @(negedge clk);
        req_valid = 1; req_signed = 0;
        req_dividend = 9; req_divisor = 3; flush = 1;
        @(negedge clk);
        req_valid = 0; flush = 0;
        ens = 0; dones = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (div_en) ens++;
            if (done) dones++;
        end
        chk("fidle_en", ens, 0);
        chk("fidle_done", dones, 0);
        chk("fidle_lo", lo, 2);

        // flush 5 cycles into WAIT
        @(negedge clk);
        req_valid = 1; req_signed = 0;
        req_dividend = 20; req_divisor = 6;
        @(negedge clk);
        req_valid = 0;
        repeat (5) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        #1;
        chk("flush_state", dut.state_q, 2'b11);
        dones = 0; n = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (done) dones++;
            if (!stall) begin
                n = i;
                break;
            end
        end
        chk("flush_drained", n >= 0, 1);
        chk("flush_done", dones, 0);
        chk("flush_hi", hi, 32'hFFFF_FFFE);
        chk("flush_lo", lo, 2);
        run_div(1'b1, 32'd10, 32'd3, ens, lat, dones, st_ok);
        chk("after_flush_lo", lo, 3);
        chk("after_flush_hi", hi, 1);
        chk("after_flush_lat", lat, 36);

        // mtlo collides with a request in IDLE
        @(negedge clk);
        mt_lo_we = 1; mt_wdata = 32'h1234;
        req_valid = 1; req_signed = 0;
        req_dividend = 8; req_divisor = 2;
        #1;
        chk("mt_ready0", req_ready, 0);
        chk("mt_stall0", stall, 0);
        @(negedge clk);
        mt_lo_we = 0;
        #1;
        chk("mt_lo", lo, 32'h1234);
        chk("mt_ready1", req_ready, 1);
        chk("mt_stall1", stall, 1);
        @(negedge clk);
        req_valid = 0;
        wait_done(n);
        chk("mt_div_seen", n >= 0, 1);
        chk("mt_div_lo", lo, 4);
        chk("mt_div_hi", hi, 0);
        @(negedge clk);
        mt_hi_we = 1; mt_wdata = 32'hAAAA;
        @(negedge clk);
        mt_hi_we = 0;
        #1;
        chk("mthi", hi, 32'hAAAA);

        // divider hangs: watchdog fires TO cycles after ISSUE
        hang = 1;
        @(negedge clk);
        req_valid = 1; req_signed = 0;
        req_dividend = 5; req_divisor = 5;
        first = -1; ens = 0;
        for (int i = 1; i < TO + 10; i++) begin
            @(negedge clk);
            req_valid = 0;
            #1;
            if (div_en) ens++;
            if (err_timeout && first < 0) begin
                first = i;
                chk("to_state", dut.state_q, 2'b00);
                chk("to_stall", stall, 0);
            end
        end
        chk("to_cycle", first, TO + 1);
        chk("to_en", ens, 1);
        chk("to_hi", hi, 32'hAAAA);
        chk("to_lo", lo, 4);
        chk("to_sticky", err_timeout, 1);

        // asynchronous reset mid-WAIT, then a stale complete
        hang = 0;
        @(negedge clk);
        req_valid = 1; req_signed = 0;
        req_dividend = 50; req_divisor = 5;
        @(negedge clk);
        req_valid = 0;
        repeat (10) @(negedge clk);
        #3 reset = 1;
        #1;
        chk("ar_hi", hi, 0);
        chk("ar_lo", lo, 0);
        chk("ar_err", err_timeout, 0);
        chk("ar_stall", stall, 0);
        chk("ar_en", div_en, 0);
        chk("ar_dvd", div_dividend, 0);
        chk("ar_dvs", div_divisor, 0);
        chk("ar_state", dut.state_q, 2'b00);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        stale = 1;
        @(negedge clk);
        stale = 0;
        #1;
        chk("stale_done", done, 0);
        chk("stale_lo", lo, 0);
        chk("stale_hi", hi, 0);
        chk("stale_state", dut.state_q, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Sequencing controller between the EX stage and the iterative `div` unit.
- Accepts one divide request at a time over a valid/ready handshake and pulses the divider start.
- Waits for completion, then commits quotient to LO and remainder to HI.
- Owns the HI/LO registers, including mthi/mtlo writes, raises a pipeline stall while a divide is in flight, and handles flushes and divider hangs.

Parameters:
- TIMEOUT, 64: max cycles in WAIT before abort; must be ≥ 40.
- CNT_W, 7: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  EX presents a DIV/DIVU
- req_ready  out  1  request accepted when valid&ready
- req_signed  in  1  1 = DIV, 0 = DIVU
- req_dividend  in  32  rs operand
- req_divisor  in  32  rt operand
- mt_hi_we  in  1  mthi write strobe
- mt_lo_we  in  1  mtlo write strobe
- mt_wdata  in  32  mthi/mtlo data
- flush  in  1  exception/eret flush; kills in-flight divide
- stall  out  1  freeze upstream pipeline
- hi  out  32  HI register
- lo  out  32  LO register
- done  out  1  one-cycle pulse when HI/LO committed from a divide
- err_timeout  out  1  sticky watchdog flag
- div_en  out  1  divider start, one-cycle pulse
- div_signed  out  1  to divider
- div_dividend  out  32  to divider
- div_divisor  out  32  to divider
- div_busy  in  1  from divider, unused except in assertions
- div_complete  in  1  from divider; quotient/remainder valid this cycle only
- div_quotient  in  32  from divider
- div_remainder  in  32  from divider

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - hi, lo, done, err_timeout, div_en, stall = 0; operand registers = 0.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - req_ready = ~mt_hi_we & ~mt_lo_we; mt writes win the cycle.
  - mt_hi_we writes hi; mt_lo_we writes lo; both may fire together.
  - On accept with divisor != 0: latch operands and signedness, go to ISSUE.
  - On accept with divisor == 0: hi/lo unchanged, done=1 next cycle, stay IDLE.
- ISSUE:
  - div_en=1 for exactly this cycle; operand outputs driven from the latches.
  - Next state WAIT; watchdog cleared.
- WAIT:
  - Count cycles.
  - On div_complete=1: lo<=div_quotient, hi<=div_remainder, done=1 next cycle, go to IDLE.
  - When count reaches TIMEOUT without complete: err_timeout<=1, hi/lo unchanged, go to IDLE.
- DRAIN:
  - Entered when flush=1 in ISSUE or WAIT; the divider cannot abort.
  - Wait for div_complete, discard results, go to IDLE. The watchdog applies here too.
- flush in IDLE: no effect, except that a request accepted the same cycle is dropped (no ISSUE).
- flush takes priority over div_complete in the same cycle: results are discarded and the next state is IDLE.
- stall = (state != IDLE) | (req_valid & req_ready & divisor != 0) in the accept cycle. Combinational; the pipeline holds the instruction after the DIV.
- mt writes outside IDLE are ignored; the pipeline is stalled, so none are legal.
- req_ready=0 outside IDLE.
- div_en is never high in two consecutive cycles.
- div_signed, div_dividend and div_divisor are stable from ISSUE through completion.
- Latency, no flush: accept at cycle N → div_en at N+1 → commit at the cycle after div_complete (≈N+36 with the current divider) → done pulse that cycle.
- err_timeout is cleared only by reset.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, DRAIN=2'b11)
  - DIV_TIMEOUT default
- One sub-module, `hilo_regs`: holds the HI/LO registers with the mt write port and the divide commit port; commit has priority, though the two are never simultaneous by construction.
- The FSM and watchdog stay in div_sched.

Test Plan:
- Signed: DIV -7/2 with the real div instance → exactly one div_en pulse; after completion lo=0xFFFFFFFD, hi=0xFFFFFFFF, done pulses once; stall high from accept until done.
- Unsigned: DIVU 0xFFFFFFFF/16 → lo=0x0FFFFFFF, hi=0xF. Then DIVU 100/0 → no div_en, hi/lo unchanged, done one cycle after accept, stall low.
- Flush: flush asserted 5 cycles into WAIT → state DRAIN; when div_complete arrives hi/lo keep their prior values and there is no done. Then an immediately following DIV 10/3 → lo=3, hi=1.
- mt collision: mtlo 0x1234 and req_valid in the same IDLE cycle → lo=0x1234, req_ready=0 that cycle; the request is accepted on the next cycle.
- Timeout: stub divider that never raises div_complete → err_timeout=1 exactly TIMEOUT cycles after ISSUE, state back to IDLE, stall drops, hi/lo unchanged.
- Reset mid-WAIT: assert reset asynchronously (not clock-aligned) → all outputs 0 immediately, state IDLE. A stale div_complete after reset release is ignored.
